bus_arbiter: RTL and testbench

- Two-master arbiter for the shared CPU bus (bus_data/bus_addr/wr/rd) feeding the instruction memory, data RAM and pio.
- Master 0 is the risc core; master 1 is a second bus master, e.g. a program loader or debug port.
- Grants are round-robin with a bounded hold time and one dead turnaround cycle between owners, so bus_data never has two drivers.
- Owns the only drivers of bus_addr, wr and rd, and the master-side driver of bus_data.

---
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared CPU bus, with bounded hold time
// and a one-cycle dead turnaround between owners so bus_data never has two drivers.
module bus_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_wr,
   input  logic              m0_rd,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_gnt,

   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_wr,
   input  logic              m1_rd,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_gnt,

   output logic [ADDR_W-1:0] bus_addr,
   inout  wire  [DATA_W-1:0] bus_data,
   output logic              wr,
   output logic              rd,
   output logic              preempt
);

   localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HoldSat  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam bit PreemptEn = (MAX_HOLD > 0);

   typedef enum logic [1:0] {
      StIdle,
      StGnt0,
      StGnt1,
      StTurn
   } state_e;

   state_e            state;
   logic              last;
   logic [HOLD_W-1:0] hold_cnt;

   logic              pick_valid;
   logic              pick;
   logic              own_req;
   logic              other_req;
   logic              cur_owner;
   logic              hold_up;
   logic [DATA_W-1:0] wdata;

   // Round-robin choice used from IDLE and TURN; a tie goes to the master that was not last.
   always_comb begin
      pick_valid = m0_req | m1_req;
      if (m0_req && m1_req) begin
         pick = ~last;
      end else begin
         pick = m1_req;
      end
   end

   // Hold limit reached: hold_cnt may already sit saturated when the other master arrives.
   always_comb begin
      cur_owner = (state == StGnt1);
      own_req   = cur_owner ? m1_req : m0_req;
      other_req = cur_owner ? m0_req : m1_req;
      hold_up   = PreemptEn && other_req && ((hold_cnt == HoldLast) || (hold_cnt == HoldSat));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= StIdle;
         last     <= 1'b1;
         hold_cnt <= '0;
         m0_gnt   <= 1'b0;
         m1_gnt   <= 1'b0;
         preempt  <= 1'b0;
      end else begin
         case (state)
            StIdle, StTurn: begin
               preempt <= 1'b0;
               if (pick_valid) begin
                  state    <= pick ? StGnt1 : StGnt0;
                  m0_gnt   <= ~pick;
                  m1_gnt   <= pick;
                  hold_cnt <= '0;
               end else begin
                  state  <= StIdle;
                  m0_gnt <= 1'b0;
                  m1_gnt <= 1'b0;
               end
            end
            StGnt0, StGnt1: begin
               if (!own_req || hold_up) begin
                  state   <= StTurn;
                  last    <= cur_owner;
                  m0_gnt  <= 1'b0;
                  m1_gnt  <= 1'b0;
                  preempt <= own_req;
               end else begin
                  preempt <= 1'b0;
                  if (hold_cnt != HoldSat) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state   <= StIdle;
               m0_gnt  <= 1'b0;
               m1_gnt  <= 1'b0;
               preempt <= 1'b0;
            end
         endcase
      end
   end

   // Bus muxing follows the registered grants; a write strobe masks a simultaneous read.
   always_comb begin
      bus_addr = '0;
      wr       = 1'b0;
      rd       = 1'b0;
      wdata    = '0;
      if (m0_gnt) begin
         bus_addr = m0_addr;
         wr       = m0_wr;
         rd       = m0_rd & ~m0_wr;
         wdata    = m0_wdata;
      end else if (m1_gnt) begin
         bus_addr = m1_addr;
         wr       = m1_wr;
         rd       = m1_rd & ~m1_wr;
         wdata    = m1_wdata;
      end
   end

   assign bus_data = wr ? wdata : {DATA_W{1'bz}};

   assign m0_rdata = (m0_gnt && rd) ? bus_data : '0;
   assign m1_rdata = (m1_gnt && rd) ? bus_data : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one instance with MAX_HOLD=4 and one with MAX_HOLD=0 share stimulus,
// each compared every cycle against an owner/hold-count reference model.
module tb_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        m0_req, m0_wr, m0_rd, m1_req, m1_wr, m1_rd;
   logic [12:0] m0_addr, m1_addr;
   logic [7:0]  m0_wdata, m1_wdata;
   logic [7:0]  mem_val;

   wire  [7:0]  a_bus, n_bus;
   logic [7:0]  a_rd0, a_rd1, n_rd0, n_rd1;
   logic [12:0] a_addr, n_addr;
   logic        a_g0, a_g1, a_pre, a_wr, a_rd;
   logic        n_g0, n_g1, n_pre, n_wr, n_rd;

   typedef struct {
      int owner;  // -1 when nobody holds the bus
      int last;
      int held;   // grant cycles so far, 1 on the first
      bit pre;
   } mdl_t;

   mdl_t ma, mn;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic a_drv, n_drv;
   assign a_drv = !((ma.owner == 0 && m0_wr) || (ma.owner == 1 && m1_wr));
   assign n_drv = !((mn.owner == 0 && m0_wr) || (mn.owner == 1 && m1_wr));
   assign a_bus = a_drv ? mem_val : 8'hzz;
   assign n_bus = n_drv ? mem_val : 8'hzz;

   bus_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_wdata(m0_wdata), .m0_rdata(a_rd0), .m0_gnt(a_g0),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_wdata(m1_wdata), .m1_rdata(a_rd1), .m1_gnt(a_g1),
      .bus_addr(a_addr), .bus_data(a_bus), .wr(a_wr), .rd(a_rd), .preempt(a_pre)
   );

   bus_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_HOLD(0)) dut_nh (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_wdata(m0_wdata), .m0_rdata(n_rd0), .m0_gnt(n_g0),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_wdata(m1_wdata), .m1_rdata(n_rd1), .m1_gnt(n_g1),
      .bus_addr(n_addr), .bus_data(n_bus), .wr(n_wr), .rd(n_rd), .preempt(n_pre)
   );

   function automatic mdl_t mdl_step(input mdl_t s, input bit rst, input bit r0, input bit r1,
                                     input int maxh);
      mdl_t n;
      bit   own, oth;
      n = s;
      if (!rst) begin
         n.owner = -1;
         n.last  = 1;
         n.held  = 0;
         n.pre   = 1'b0;
         return n;
      end
      n.pre = 1'b0;
      if (s.owner >= 0) begin
         own = (s.owner == 0) ? r0 : r1;
         oth = (s.owner == 0) ? r1 : r0;
         if (!own || (maxh > 0 && oth && s.held >= maxh)) begin
            n.pre   = own;
            n.last  = s.owner;
            n.owner = -1;
         end else begin
            n.held = s.held + 1;
         end
      end else if (r0 || r1) begin
         n.owner = (r0 && r1) ? 1 - s.last : (r0 ? 0 : 1);
         n.held  = 1;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string p, input mdl_t s, input logic g0, input logic g1,
                          input logic pre, input logic w, input logic r, input logic [12:0] addr,
                          input logic [7:0] rd0, input logic [7:0] rd1, input logic [7:0] bus);
      logic        ew, er;
      logic [12:0] ea;
      logic [7:0]  ewd;
      ew = 1'b0; er = 1'b0; ea = '0; ewd = '0;
      if (s.owner == 0) begin
         ea = m0_addr; ew = m0_wr; er = m0_rd && !m0_wr; ewd = m0_wdata;
      end else if (s.owner == 1) begin
         ea = m1_addr; ew = m1_wr; er = m1_rd && !m1_wr; ewd = m1_wdata;
      end
      chk({p, "_gnt0"}, g0, 32'(s.owner == 0));
      chk({p, "_gnt1"}, g1, 32'(s.owner == 1));
      chk({p, "_preempt"}, pre, 32'(s.pre));
      chk({p, "_addr"}, addr, ea);
      chk({p, "_wr"}, w, ew);
      chk({p, "_rd"}, r, er);
      chk({p, "_rdata0"}, rd0, (s.owner == 0 && er) ? mem_val : 8'h00);
      chk({p, "_rdata1"}, rd1, (s.owner == 1 && er) ? mem_val : 8'h00);
      if (ew) chk({p, "_bus_wdata"}, bus, ewd);
      else    chk({p, "_bus_free"}, bus, mem_val);
   endtask

   // Check the current cycle, clock the DUTs and the models, return at the next negedge.
   task automatic tick();
      #1;
      chk_dut("a", ma, a_g0, a_g1, a_pre, a_wr, a_rd, a_addr, a_rd0, a_rd1, a_bus);
      chk_dut("n", mn, n_g0, n_g1, n_pre, n_wr, n_rd, n_addr, n_rd0, n_rd1, n_bus);
      @(posedge clk);
      ma = mdl_step(ma, rst_n, m0_req, m1_req, 4);
      mn = mdl_step(mn, rst_n, m0_req, m1_req, 0);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_wr = 0; m0_rd = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_rd = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      mem_val = 8'h00;
      idle_inputs();
      ma = mdl_step(ma, 1'b0, 1'b0, 1'b0, 4);
      mn = mdl_step(mn, 1'b0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      tick();
      #1;
      chk("rst_gnt0", a_g0, 0);
      chk("rst_gnt1", a_g1, 0);
      chk("rst_preempt", a_pre, 0);
      chk("rst_wr", a_wr, 0);
      chk("rst_addr", a_addr, 0);

      // Single master read
      rst_n = 1'b1;
      tick();
      m0_req = 1; m0_addr = 13'h0005; m0_rd = 1; mem_val = 8'hA5;
      tick();
      #1;
      chk("t1_gnt0", a_g0, 1);
      chk("t1_addr", a_addr, 13'h0005);
      chk("t1_rd", a_rd, 1);
      chk("t1_rdata0", a_rd0, 8'hA5);
      chk("t1_rdata1", a_rd1, 8'h00);

      // Tie after reset goes to m0, release then handover through TURN
      do_reset();
      m0_req = 1; m1_req = 1;
      tick();
      #1;
      chk("t2_first0", a_g0, 1);
      chk("t2_not1", a_g1, 0);
      m0_req = 0;
      tick();
      #1;
      chk("t2_turn_g0", a_g0, 0);
      chk("t2_turn_g1", a_g1, 0);
      chk("t2_turn_wr", a_wr, 0);
      chk("t2_turn_rd", a_rd, 0);
      tick();
      #1;
      chk("t2_g1", a_g1, 1);

      // Preemption after four cycles with MAX_HOLD=4
      do_reset();
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("t3_hold", a_g0, 1);
         chk("t3_nopre", a_pre, 0);
      end
      tick();
      #1;
      chk("t3_rel", a_g0, 0);
      chk("t3_rel_g1", a_g1, 0);
      chk("t3_pre", a_pre, 1);
      tick();
      #1;
      chk("t3_g1", a_g1, 1);
      chk("t3_pre_off", a_pre, 0);
      m1_req = 0;
      tick();
      #1;
      chk("t3_turn_g1", a_g1, 0);
      chk("t3_turn_g0", a_g0, 0);
      chk("t3_turn_pre", a_pre, 0);
      tick();
      #1;
      chk("t3_regrant", a_g0, 1);

      // m1 write wins over read; m0 strobes ignored
      do_reset();
      mem_val = 8'h96;
      m1_req = 1; m1_wr = 1; m1_rd = 1; m1_addr = 13'h1F00; m1_wdata = 8'h3C;
      m0_wr = 1; m0_rd = 1; m0_addr = 13'h0AAA; m0_wdata = 8'h55;
      tick();
      #1;
      chk("t4_g1", a_g1, 1);
      chk("t4_wr", a_wr, 1);
      chk("t4_rd", a_rd, 0);
      chk("t4_bus", a_bus, 8'h3C);
      chk("t4_addr", a_addr, 13'h1F00);

      // Reset mid-grant
      rst_n = 1'b0;
      tick();
      #1;
      chk("t5_g1", a_g1, 0);
      chk("t5_wr", a_wr, 0);
      chk("t5_bus_free", a_bus, 8'h96);
      rst_n = 1'b1;
      idle_inputs();
      m0_req = 1; m1_req = 1;
      tick();
      #1;
      chk("t5_tie", a_g0, 1);

      // MAX_HOLD=0: m0 keeps the bus indefinitely
      for (int i = 0; i < 50; i++) begin
         tick();
         #1;
         chk("t6_g0", n_g0, 1);
         chk("t6_pre", n_pre, 0);
      end

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) m0_req = ~m0_req;
         if ($urandom_range(0, 5) == 0) m1_req = ~m1_req;
         m0_wr    = ($urandom_range(0, 2) == 0);
         m0_rd    = ($urandom_range(0, 1) == 0);
         m1_wr    = ($urandom_range(0, 2) == 0);
         m1_rd    = ($urandom_range(0, 1) == 0);
         m0_addr  = 13'($urandom);
         m1_addr  = 13'($urandom);
         m0_wdata = 8'($urandom);
         m1_wdata = 8'($urandom);
         mem_val  = 8'($urandom);
         rst_n    = ($urandom_range(0, 99) != 0);
         tick();
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
